sequential_left_shifter: RTL and testbench
==========================================

SEQUENTIAL_LEFT_SHIFTER -- requirements
Module: sequential_left_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data and result width in bits.
REQ-002 SHALL have parameter SHAMT_W, default 5: shift-amount width; WIDTH = 2**SHAMT_W.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: synchronous reset, active-high.
REQ-005 SHALL have port start  input  1: request a shift; sampled only while ready=1.
REQ-006 SHALL have port data  input  WIDTH: operand; captured on the accepted start.
REQ-007 SHALL have port shift_amount  input  SHAMT_W: left-shift count 0..WIDTH-1; captured on the accepted start.
REQ-008 SHALL have port ready  output  1: high only in IDLE, meaning start will be accepted.
REQ-009 SHALL have port done  output  1: one-cycle pulse; result and overflow are valid.
REQ-010 SHALL have port output_data  output  WIDTH: registered result, data << shift_amount, zero-filled from the LSB.
REQ-011 SHALL have port overflow  output  1: registered flag; signed arithmetic-left overflow of the last operation.

Function
REQ-012 SHALL implement an FSM with the states IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1, SHALL load the work register with data and the counter with shift_amount, clear the internal overflow accumulator, and go to DONE if shift_amount=0, otherwise to SHIFT.
REQ-014 In IDLE with start=0, SHALL stay in IDLE with all registers held.
REQ-015 In SHIFT, each cycle SHALL perform work <= {work[WIDTH-2:0],1'b0}, decrement the counter, and OR (work[WIDTH-1] XOR work[WIDTH-2]) into the accumulator, using the work value before the shift.
REQ-016 In SHIFT, SHALL go to DONE on the cycle the counter decrements from 1 to 0, and otherwise stay in SHIFT.
REQ-017 On the transition into DONE, SHALL register output_data from the final work value and overflow from the final accumulator value.
REQ-018 In DONE, SHALL assert done=1 for exactly one cycle, then return unconditionally to IDLE.
REQ-019 For a start accepted in cycle N with amount k, done SHALL be high in cycle N+1+k (latency 1 for k=0, 32 for k=31).
REQ-020 SHALL hold output_data and overflow stable from DONE until the next DONE; they SHALL NOT change while shifting.
REQ-021 SHALL ignore start while in SHIFT or DONE; inputs are not captured and no state is affected.
REQ-022 SHALL ignore data and shift_amount changes after the start is accepted; the captured values are used.
REQ-023 SHALL permit back-to-back operation: a start held high re-accepts in the first IDLE cycle after DONE.
REQ-024 Overflow SHALL equal 1 iff the signed value data*2**k is not representable in WIDTH bits.
REQ-025 Overflow SHALL equal 1 iff bits [WIDTH-1 : WIDTH-1-k] of data are not all equal.

Reset
REQ-026 When rst=1 at a rising edge, SHALL enter IDLE and clear the work register, counter, accumulator, output_data, overflow and done to 0.
REQ-027 rst SHALL take priority over start and over any in-progress operation; an aborted operation produces no done pulse.
REQ-028 After reset, ready SHALL be 1 from the first cycle in which rst=0.

Verification
REQ-029 Directed: data=0x00000001, k=4, start in cycle N -> done in N+5, output_data=0x00000010, overflow=0.
REQ-030 Directed: data=0xDEADBEEF, k=0 -> done in N+1, output_data=0xDEADBEEF, overflow=0.
REQ-031 Directed: data=0x40000000, k=1 -> output_data=0x80000000, overflow=1; data=0xFFFFFFFF, k=31 -> output_data=0x80000000, overflow=0, done in N+32.
REQ-032 Directed: data=0x00000001, k=31 -> output_data=0x80000000, overflow=1; a second start pulse and changed data in N+3 -> ignored, with the result unchanged.
REQ-033 Directed: start with k=20, then assert rst in N+10 -> no done pulse, ready=1 and output_data=0 after reset, and the next operation is correct.
REQ-034 Bench SHALL compare every done against a reference model of the left-shift and overflow rule, with random data and k, for at least 1000 operations.

Source files
------------

// File: rtl/sequential_left_shifter.sv
// Bit-serial left shifter: one position per cycle, with signed arithmetic-left
// overflow detection accumulated from the top two bits as they shift out.
module sequential_left_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] shift_amount,
  output logic               ready,
  output logic               done,
  output logic [WIDTH-1:0]   output_data,
  output logic               overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
  localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   work_r, work_s;
  logic [WIDTH-1:0]   out_r, out_s;
  logic [SHAMT_W-1:0] count_r, count_s;
  logic               acc_r, acc_s;
  logic               ovf_r, ovf_s;
  logic               done_r, done_s;
  logic               ready_r, ready_s;
  logic [WIDTH-1:0]   work_shl_s;
  logic               step_ovf_s;

  // A left shift by one loses the sign iff the two top bits differ.
  function automatic logic top_pair_differs(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ^ v[WIDTH-2];
  endfunction

  // Next-state and next-datapath logic; everything holds unless a state acts.
  always_comb begin
    state_s    = state_r;
    work_s     = work_r;
    out_s      = out_r;
    count_s    = count_r;
    acc_s      = acc_r;
    ovf_s      = ovf_r;
    work_shl_s = {work_r[WIDTH-2:0], 1'b0};
    step_ovf_s = top_pair_differs(work_r);
    case (state_r)
      IDLE: begin
        if (start) begin
          work_s  = data;
          count_s = shift_amount;
          acc_s   = 1'b0;
          if (shift_amount == CNT_ZERO) begin
            state_s = DONE;
            out_s   = data;
            ovf_s   = 1'b0;
          end else begin
            state_s = SHIFT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        work_s  = work_shl_s;
        count_s = count_r - CNT_ONE;
        acc_s   = acc_r | step_ovf_s;
        if (count_r == CNT_ONE) begin
          state_s = DONE;
          out_s   = work_shl_s;
          ovf_s   = acc_r | step_ovf_s;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    ready_s = (state_s == IDLE);
    done_s  = (state_s == DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      work_r  <= {WIDTH{1'b0}};
      out_r   <= {WIDTH{1'b0}};
      count_r <= CNT_ZERO;
      acc_r   <= 1'b0;
      ovf_r   <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_s;
      work_r  <= work_s;
      out_r   <= out_s;
      count_r <= count_s;
      acc_r   <= acc_s;
      ovf_r   <= ovf_s;
      done_r  <= done_s;
      ready_r <= ready_s;
    end
  end

  assign ready       = ready_r;
  assign done        = done_r;
  assign output_data = out_r;
  assign overflow    = ovf_r;

endmodule

// File: tb/tb_sequential_left_shifter.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// random operations, all scored through an expected-result queue.
module tb_sequential_left_shifter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] data;
  logic [4:0]  shift_amount;
  logic        ready;
  logic        done;
  logic [31:0] output_data;
  logic        overflow;

  typedef struct {
    logic [31:0] out;
    logic        ovf;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  k;
    logic [31:0] out;
    logic        ovf;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[5];
  int          n_pass  = 0;
  int          n_total = 0;
  int          cyc     = 0;
  logic [31:0] last_out = 32'h0;

  sequential_left_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .data         (data),
    .shift_amount (shift_amount),
    .ready        (ready),
    .done         (done),
    .output_data  (output_data),
    .overflow     (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: sign-extend to 64 bits, shift, and test whether the 32-bit result still represents it.
  function automatic exp_t model(input logic [31:0] d, input int k, input int at);
    exp_t e;
    logic signed [63:0] p;
    p = $signed(d);
    p = p <<< k;
    e.out = p[31:0];
    e.ovf = (p != {{32{p[31]}}, p[31:0]});
    e.cyc = at;
    return e;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL spurious_done: done=1 with nothing outstanding (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result",   output_data, e.out);
        check("overflow", {31'b0, overflow}, {31'b0, e.ovf});
        check("latency",  32'(cyc), 32'(e.cyc));
        last_out = e.out;
      end
    end
  end

  task automatic wait_ready();
    int w = 0;
    while (ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (ready !== 1'b1) begin
      n_total++;
      $display("FAIL ready_timeout: ready=%b want 1", ready);
    end
  endtask

  // Issue one operation from a negedge and scramble the inputs once it is taken.
  task automatic start_op(input logic [31:0] d, input logic [4:0] k,
                          input logic [31:0] eout, input logic eovf);
    exp_t e;
    wait_ready();
    start = 1'b1;
    data = d;
    shift_amount = k;
    e.out = eout;
    e.ovf = eovf;
    e.cyc = cyc + 1 + int'(k);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    data = $urandom;
    shift_amount = 5'($urandom);
  endtask

  task automatic start_model(input logic [31:0] d, input logic [4:0] k);
    exp_t e;
    e = model(d, int'(k), 0);
    start_op(d, k, e.out, e.ovf);
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((sb.size() != 0 || ready !== 1'b1) && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL done_timeout: %0d results outstanding, want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    vecs[0] = '{32'h00000001, 5'd4,  32'h00000010, 1'b0};
    vecs[1] = '{32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b0};
    vecs[2] = '{32'h40000000, 5'd1,  32'h80000000, 1'b1};
    vecs[3] = '{32'hFFFFFFFF, 5'd31, 32'h80000000, 1'b0};
    vecs[4] = '{32'h00000001, 5'd31, 32'h80000000, 1'b1};

    rst = 1'b1;
    start = 1'b0;
    data = 32'h0;
    shift_amount = 5'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_ready",    {31'b0, ready},    32'h1);
    check("reset_done",     {31'b0, done},     32'h0);
    check("reset_out",      output_data,       32'h0);
    check("reset_overflow", {31'b0, overflow}, 32'h0);

    for (int i = 0; i < 5; i++) begin
      start_op(vecs[i].d, vecs[i].k, vecs[i].out, vecs[i].ovf);
      wait_idle();
    end

    // Start pulse and new operands in N+3 of a long shift must be ignored.
    start_op(32'h00000001, 5'd31, 32'h80000000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    data = 32'hFFFF0000;
    shift_amount = 5'd0;
    check("hold_while_shift", output_data, last_out);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("after_ignored_start", output_data, 32'h80000000);

    // Start held high: second operation accepted in the first IDLE cycle after DONE.
    begin
      exp_t e;
      start = 1'b1;
      data = 32'h00000005;
      shift_amount = 5'd2;
      e = model(32'h00000005, 2, cyc + 3);
      sb.push_back(e);
      @(negedge clk);
      data = 32'hC0000001;
      shift_amount = 5'd3;
      e = model(32'hC0000001, 3, cyc + 7);
      sb.push_back(e);
      repeat (3) @(negedge clk);
      check("b2b_ready", {31'b0, ready}, 32'h1);
      @(negedge clk);
      start = 1'b0;
      wait_idle();
    end

    // Reset in N+10 of a k=20 shift aborts it with no done pulse.
    start = 1'b1;
    data = 32'h12345678;
    shift_amount = 5'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_out = 32'h0;
    check("abort_ready",    {31'b0, ready},    32'h1);
    check("abort_done",     {31'b0, done},     32'h0);
    check("abort_out",      output_data,       32'h0);
    check("abort_overflow", {31'b0, overflow}, 32'h0);
    repeat (25) @(negedge clk);
    start_op(32'h00000003, 5'd5, 32'h00000060, 1'b0);
    wait_idle();

    // Random operations, biased so both overflow outcomes are common.
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] d;
      logic [31:0] r;
      r = $urandom;
      d = $urandom;
      if (i % 3 == 0) d = {32{r[0]}} ^ (d >> $urandom_range(0, 31));
      start_model(d, 5'($urandom_range(0, 31)));
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
